// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter.
// Optional feature macro used by the arbiter files: MEM_ARB_LOCK_EN.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    RDONE  = 2'd3
  } arbState_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_LDR = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick.
// With MEM_ARB_LOCK_EN defined, a held lock from the last winner
// masks the other requester so it can finish an atomic sequence.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
`ifdef MEM_ARB_LOCK_EN
  input  logic lock0,
  input  logic lock1,
`endif
  output logic winIdx,
  output logic anyReq
);

  logic effReq0;
  logic effReq1;

`ifdef MEM_ARB_LOCK_EN
  logic lockHeld;

  // The last winner's lock shuts out the other side; if the lock holder
  // is not requesting, nobody is eligible and the sequencer waits.
  assign lockHeld = (last == REQ_LDR) ? lock1 : lock0;
  assign effReq0  = req0 && !(lockHeld && (last == REQ_LDR));
  assign effReq1  = req1 && !(lockHeld && (last == REQ_CPU));
`else
  assign effReq0  = req0;
  assign effReq1  = req1;
`endif

  assign anyReq = effReq0 | effReq1;

  // On a tie the requester that did not win last time goes next.
  assign winIdx = (effReq0 && effReq1) ? ~last
                : (effReq1 ? REQ_LDR : REQ_CPU);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter and sequencer for the single synchronous memory port shared by
// the CPU (requester 0) and the loader/debug port (requester 1).
// Define MEM_ARB_LOCK_EN to add lock0/lock1 for exclusive access.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef MEM_ARB_LOCK_EN
  input  logic                  lock0,
  input  logic                  lock1,
`endif
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic [DATA_WIDTH-1:0] mem_in,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data
);

  arbState_t             state;
  logic                  lastGnt;
  logic                  curIdx;
  logic                  winIdx;
  logic                  anyReq;
  logic                  winWe;
  logic [ADDR_WIDTH-1:0] winAddr;
  logic [DATA_WIDTH-1:0] winData;

  rr_arb2 uArb (
    .req0   (req0),
    .req1   (req1),
    .last   (lastGnt),
`ifdef MEM_ARB_LOCK_EN
    .lock0  (lock0),
    .lock1  (lock1),
`endif
    .winIdx (winIdx),
    .anyReq (anyReq)
  );

  // Select the command of the requester the round-robin picked.
  always_comb begin
    // NOTE: every output gets a default before the branch so no latch is inferred.
    winWe   = we0;
    winAddr = addr0;
    winData = wdata0;
    if (winIdx == REQ_LDR) begin
      winWe   = we1;
      winAddr = addr1;
      winData = wdata1;
    end
  end

  // Sequencer: grant, drive the memory, capture read data, signal valid.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // sees the pre-edge values of the others, matching the hardware.
    if (!rst_n) begin
      state    <= IDLE;
      lastGnt  <= REQ_LDR;
      curIdx   <= REQ_CPU;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      rdata    <= '0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
    end else begin
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      mem_we  <= 1'b0;
      case (state)
        IDLE: begin
          if (anyReq) begin
            curIdx   <= winIdx;
            lastGnt  <= winIdx;
            mem_we   <= winWe;
            mem_addr <= winAddr;
            mem_data <= winData;
            gnt0     <= (winIdx == REQ_CPU);
            gnt1     <= (winIdx == REQ_LDR);
            state    <= ACCESS;
          end
        end
        // mem_we holds the latched command type while in ACCESS.
        ACCESS: state <= mem_we ? IDLE : RESP;
        RESP: begin
          rdata   <= mem_in;
          rvalid0 <= (curIdx == REQ_CPU);
          rvalid1 <= (curIdx == REQ_LDR);
          state   <= RDONE;
        end
        RDONE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a table of request vectors,
// a grant/read-data scoreboard, and hand sequences for reset-in-RESP,
// held-request alternation and (with MEM_ARB_LOCK_EN) locked access.
module tb_mem_port_arbiter;
  localparam int AW = 6;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, mem_we;
  logic [DW-1:0] rdata, mem_in, mem_data;
  logic [AW-1:0] mem_addr;
`ifdef MEM_ARB_LOCK_EN
  logic          lock0 = 1'b0, lock1 = 1'b0;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef MEM_ARB_LOCK_EN
    .lock0    (lock0),
    .lock1    (lock1),
`endif
    .req0     (req0),
    .we0      (we0),
    .addr0    (addr0),
    .wdata0   (wdata0),
    .req1     (req1),
    .we1      (we1),
    .addr1    (addr1),
    .wdata1   (wdata1),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .rvalid0  (rvalid0),
    .rvalid1  (rvalid1),
    .rdata    (rdata),
    .mem_in   (mem_in),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_data (mem_data)
  );

  function automatic logic [DW-1:0] initVal(input int i);
    if (i == 63) return 16'hBEEF;
    return 16'(i * 257) ^ 16'h3C00;
  endfunction

  // Behavioural 64x16 synchronous memory, reloaded while reset is low.
  logic [DW-1:0] mem [64];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) mem[i] <= initVal(i);
    end else if (mem_we) begin
      mem[mem_addr] <= mem_data;
    end
    mem_in <= mem[mem_addr];
  end

  logic [DW-1:0] refMem [64];
  task automatic initRef();
    for (int i = 0; i < 64; i++) refMem[i] = initVal(i);
  endtask

  int nChecks = 0;
  int nPass = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  typedef struct packed {
    logic          idx;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } gntExp_t;
  typedef struct packed {
    logic          idx;
    logic [DW-1:0] data;
  } rdExp_t;

  gntExp_t gntQ[$];
  rdExp_t  rdQ[$];

  task automatic pushCmd(input logic idx, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    gntQ.push_back('{idx, we, a, d});
    if (we) refMem[a] = d;
    else rdQ.push_back('{idx, refMem[a]});
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin : monitor
    gntExp_t ge;
    rdExp_t  re;
    if (rst_n) begin
      if (gnt0 || gnt1) begin
        if (gntQ.size() == 0) begin
          check("gnt_unexpected", {30'd0, gnt1, gnt0}, 32'd0);
        end else begin
          ge = gntQ.pop_front();
          check("gnt_idx", {30'd0, gnt1, gnt0}, ge.idx ? 32'd2 : 32'd1);
          check("mem_we", {31'd0, mem_we}, {31'd0, ge.we});
          check("mem_addr", {26'd0, mem_addr}, {26'd0, ge.addr});
          if (ge.we) check("mem_data", {16'd0, mem_data}, {16'd0, ge.data});
        end
      end else begin
        check("mem_we_idle", {31'd0, mem_we}, 32'd0);
      end
      if (rvalid0 || rvalid1) begin
        if (rdQ.size() == 0) begin
          check("rvalid_unexpected", {30'd0, rvalid1, rvalid0}, 32'd0);
        end else begin
          re = rdQ.pop_front();
          check("rvalid_idx", {30'd0, rvalid1, rvalid0}, re.idx ? 32'd2 : 32'd1);
          check("rdata", {16'd0, rdata}, {16'd0, re.data});
        end
      end
    end
  end

  typedef struct {
    logic          r0, r1, we0, we1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    logic          firstWin;
    int            rvOff;
  } vec_t;

  task automatic runVec(input int n, input vec_t v);
    int gSeen, rSeen, nG, nR, gOff, rOff;
    nG = (v.r0 ? 1 : 0) + (v.r1 ? 1 : 0);
    nR = ((v.r0 && !v.we0) ? 1 : 0) + ((v.r1 && !v.we1) ? 1 : 0);
    if (v.firstWin == 1'b0) begin
      if (v.r0) pushCmd(1'b0, v.we0, v.a0, v.d0);
      if (v.r1) pushCmd(1'b1, v.we1, v.a1, v.d1);
    end else begin
      if (v.r1) pushCmd(1'b1, v.we1, v.a1, v.d1);
      if (v.r0) pushCmd(1'b0, v.we0, v.a0, v.d0);
    end
    req0 = v.r0; we0 = v.we0; addr0 = v.a0; wdata0 = v.d0;
    req1 = v.r1; we1 = v.we1; addr1 = v.a1; wdata1 = v.d1;
    gSeen = 0; rSeen = 0; gOff = 0; rOff = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (gnt0) req0 = 1'b0;
      if (gnt1) req1 = 1'b0;
      if (gnt0 || gnt1) begin gSeen++; if (gOff == 0) gOff = c; end
      if (rvalid0 || rvalid1) begin rSeen++; if (rOff == 0) rOff = c; end
      if (gSeen >= nG && rSeen >= nR) break;
    end
    check($sformatf("vec%0d_gnt_latency", n), gOff, 1);
    if (nR > 0) check($sformatf("vec%0d_rvalid_latency", n), rOff, v.rvOff);
    check($sformatf("vec%0d_events", n), gSeen + rSeen, nG + nR);
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic checkZero(input string tag);
    check({tag, "_gnt"}, {30'd0, gnt1, gnt0}, 32'd0);
    check({tag, "_rvalid"}, {30'd0, rvalid1, rvalid0}, 32'd0);
    check({tag, "_rdata"}, {16'd0, rdata}, 32'd0);
    check({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    check({tag, "_mem_addr"}, {26'd0, mem_addr}, 32'd0);
    check({tag, "_mem_data"}, {16'd0, mem_data}, 32'd0);
  endtask

  vec_t vecs[8];

  initial begin
    int g, r, cnt;
    int gOffs[4];
    // r0 r1 we0 we1 a0 a1 d0 d1 firstWin rvOff
    vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 6'd5,  6'd0,  16'h1234, 16'h0000, 1'b0, 0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 6'd0,  6'd63, 16'h0000, 16'h0000, 1'b1, 3};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 6'd5,  6'd0,  16'h0000, 16'hA5A5, 1'b0, 3};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 6'd63, 6'd63, 16'h5555, 16'h0000, 1'b0, 5};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 6'd0,  6'd10, 16'h0000, 16'hFFFF, 1'b1, 0};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 6'd0,  6'd10, 16'h0000, 16'h0000, 1'b0, 3};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 6'd20, 6'd0,  16'h0F0F, 16'h0000, 1'b0, 0};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 6'd20, 6'd5,  16'h0000, 16'h0000, 1'b1, 3};

    initRef();
    repeat (3) @(negedge clk);
    checkZero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) runVec(i, vecs[i]);

    // Reset while a CPU read sits in RESP: outputs clear, no rvalid follows.
    pushCmd(1'b0, 1'b0, 6'd5, 16'h0000);
    req0 = 1'b1; we0 = 1'b0; addr0 = 6'd5;
    @(negedge clk);
    check("rst_seq_gnt0", {31'd0, gnt0}, 32'd1);
    req0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkZero("mid_reset");
    gntQ.delete();
    rdQ.delete();
    initRef();
    rst_n = 1'b1;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (rvalid0 || rvalid1 || gnt0 || gnt1) cnt++;
    end
    check("mid_reset_no_pulse", cnt, 0);

    // Both requesters hold read requests: grants alternate, CPU first.
    for (int i = 0; i < 2; i++) begin
      pushCmd(1'b0, 1'b0, 6'd5, 16'h0000);
      pushCmd(1'b1, 1'b0, 6'd63, 16'h0000);
    end
    req0 = 1'b1; we0 = 1'b0; addr0 = 6'd5;
    req1 = 1'b1; we1 = 1'b0; addr1 = 6'd63;
    g = 0; r = 0;
    for (int i = 0; i < 4; i++) gOffs[i] = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin
        if (g < 4) gOffs[g] = c;
        g++;
        if (g == 4) begin req0 = 1'b0; req1 = 1'b0; end
      end
      if (rvalid0 || rvalid1) r++;
      if (g >= 4 && r >= 4) break;
    end
    for (int i = 0; i < 4; i++) check($sformatf("alt_gnt%0d_cycle", i), gOffs[i], 1 + 4 * i);
    check("alt_rvalid_count", r, 4);
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);

`ifdef MEM_ARB_LOCK_EN
    // Loader locks the port for three writes while the CPU waits.
    pushCmd(1'b1, 1'b1, 6'd30, 16'h1111);
    pushCmd(1'b1, 1'b1, 6'd31, 16'h2222);
    pushCmd(1'b1, 1'b1, 6'd32, 16'h3333);
    pushCmd(1'b0, 1'b0, 6'd5, 16'h0000);
    req1 = 1'b1; lock1 = 1'b1; we1 = 1'b1; addr1 = 6'd30; wdata1 = 16'h1111;
    g = 0; r = 0; cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (gnt1) begin
        g++;
        if (g == 1) begin
          req0 = 1'b1; we0 = 1'b0; addr0 = 6'd5;
          addr1 = 6'd31; wdata1 = 16'h2222;
        end else if (g == 2) begin
          addr1 = 6'd32; wdata1 = 16'h3333;
        end else begin
          req1 = 1'b0; lock1 = 1'b0; cnt = c;
        end
      end
      if (gnt0) begin
        req0 = 1'b0;
        check("lock_gnt0_delay", c - cnt, 2);
        g++;
      end
      if (rvalid0 || rvalid1) r++;
      if (g >= 4 && r >= 1) break;
    end
    check("lock_events", g + r, 5);
    req0 = 1'b0; req1 = 1'b0; lock1 = 1'b0;
    @(negedge clk);
`endif

    check("queues_drained", gntQ.size() + rdQ.size(), 0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the single 64x16 synchronous memory port. Requester 0 is the CPU; requester 1 is the program loader/debug port. The block serialises their accesses with round-robin fairness and drives `mem_we`/`mem_addr`/`mem_data`. It returns read data with a per-requester valid pulse.

## Interface
- `ADDR_WIDTH`, default 6: memory address width.
- `DATA_WIDTH`, default 16: memory word width.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req0` / `req1`  in  1  access request; held with its command until the matching `gnt` is seen.
- `we0` / `we1`  in  1  1 = write, 0 = read; valid while `req` is high.
- `addr0` / `addr1`  in  ADDR_WIDTH  access address.
- `wdata0` / `wdata1`  in  DATA_WIDTH  write data.
- `gnt0` / `gnt1`  out  1  one-cycle pulse: command accepted.
- `rvalid0` / `rvalid1`  out  1  one-cycle pulse: `rdata` holds read result.
- `rdata`  out  DATA_WIDTH  registered read data, shared by both requesters.
- `mem_in`  in  DATA_WIDTH  memory read data, valid one cycle after address.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  ADDR_WIDTH  memory address.
- `mem_data`  out  DATA_WIDTH  memory write data.

## Operation
- FSM states:
  - IDLE: if any `req` is high, select the winner, latch its `we`/`addr`/`wdata` into the `mem_*` registers, go to ACCESS.
  - ACCESS: pulse the winner's `gnt`; `mem_we` = latched `we`. A write returns to IDLE; a read goes to RESP.
  - RESP: capture `mem_in` into `rdata`, go to RDONE.
  - RDONE: pulse the winner's `rvalid`, return to IDLE.
- Round-robin:
  - `last` records the most recently granted requester.
  - If only one `req` is high, that requester wins.
  - If both are high, the requester that is not `last` wins.
  - `last` resets to 1, so the CPU wins the first tie.
- Requester obligations:
  - Deassert `req`, or present a new command, in the cycle after `gnt`.
  - `req` is only sampled in IDLE, so a requester that holds `req` high gets a new grant.
- `mem_addr`/`mem_data` hold their value outside ACCESS/RESP until the next grant. `mem_we` is high only in ACCESS for a write.
- `rdata` holds its value until the next read capture.

## Timing
- Reset values: FSM IDLE, `last` = 1; `mem_we`, `mem_addr`, `mem_data`, `gnt0/1`, `rvalid0/1`, `rdata` all 0.
- Write: `req` sampled in IDLE at edge E → `gnt` and `mem_we` high in cycle E+1 → FSM back in IDLE at E+2. Issue rate is one write per 2 cycles.
- Read: `req` sampled at edge E → `gnt` in E+1 → memory samples address at E+2 → `mem_in` valid in E+2 → `rdata` loaded at E+3 → `rvalid` high in cycle E+3 → FSM in IDLE at E+4. Issue rate is one read per 4 cycles.
- Boundaries:
  - A request arriving in any state other than IDLE waits; it is never dropped.
  - Both requests arriving in the same cycle: the RR rule applies.
  - `addr` = 63 and `addr` = 0 are legal; there is no wrap logic.
  - Reset asserted mid-access: the next edge forces the reset values. No `gnt`/`rvalid` is issued for the aborted access. A write in ACCESS at that edge may still complete in memory.

## Configuration
- `MEM_ARB_LOCK_EN` defined:
  - Adds inputs `lock0`/`lock1` (1 bit).
  - If the last winner's `lock` is high when the FSM returns to IDLE, that requester has exclusive access. The other `req` is ignored until `lock` falls, which supports atomic read-modify-write.
  - `lock` without `req` stalls the FSM in IDLE.
- `MEM_ARB_LOCK_EN` not defined: the ports are absent and the arbiter is pure round-robin.

## Structure
- Shared package `mem_arb_pkg`: FSM state enum (IDLE, ACCESS, RESP, RDONE) and requester index constants (`REQ_CPU` = 0, `REQ_LDR` = 1).
- One sub-module, `rr_arb2`: combinational 2-way round-robin pick from `req0`, `req1`, `last` (and `lock` when enabled). It outputs the winner index and an any-valid flag.

## Test plan
- Single CPU write, `addr` = 5, `wdata` = 0x1234 → `gnt0` one cycle after the sample; `mem_we` = 1, `mem_addr` = 5, `mem_data` = 0x1234 in the same cycle; no `rvalid`.
- Loader read of `addr` = 63 with memory preloaded to 0xBEEF → `gnt1` at +1; `rvalid1` = 1 at +3 with `rdata` = 0xBEEF; `rvalid0` stays 0.
- `req0` and `req1` held high for 16 cycles, both reads → grants alternate 0,1,0,1… with the first grant to 0; no requester is granted twice in a row.
- Synchronous reset asserted in RESP → next cycle all outputs are 0, state is IDLE, and no `rvalid` pulse occurs.
- With `MEM_ARB_LOCK_EN`: `lock1` held high during 3 loader accesses while `req0` is high → `gnt0` is withheld until `lock1` drops, then is granted within 1 cycle of IDLE.
